// File: rtl/aes_sub_bytes_serial.sv
// aes_sub_bytes_serial
// Iterative AES SubBytes stage. A 128-bit state is captured over a valid/ready
// handshake, then LANES bytes per cycle are passed through LANES shared forward
// S-box lookups, lowest byte group first. The substituted state is held on
// `out` until the downstream stage takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. in_ready, out_valid and busy are pure decodes of the registered
// FSM state, so no input reaches any output combinationally. Exactly one of
// in_ready (IDLE), busy (BUSY) and out_valid (DONE) is high at any time, which
// makes the three of them a complete view of the FSM state.
module aes_sub_bytes_serial #(
    parameter int DATA_W = 128,
    parameter int LANES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out,
    output logic              busy
);

    // Number of byte groups and width of the group counter (at least 1 bit).
    localparam int GROUPS = 16 / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    // FIPS-197 forward S-box, indexed by the input byte.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Only the 128-bit AES state and power-of-two lane counts up to 16 are supported.
    if (DATA_W != 128) begin : g_bad_data_w
        $error("aes_sub_bytes_serial: DATA_W must be 128");
    end
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_sub_bytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]       r_state;
    logic [127:0]     r_work;
    logic [CNT_W-1:0] r_cnt;

    logic [6:0]       w_lane_pos [LANES];
    logic [7:0]       w_lane_in  [LANES];
    logic [7:0]       w_lane_out [LANES];
    logic [127:0]     w_work_sub;

    // One combinational S-box lookup per lane; lane l handles byte cnt*LANES+l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_pos[l] = 7'((int'(r_cnt) * LANES + l) * 8);
        assign w_lane_in[l]  = r_work[w_lane_pos[l] +: 8];
        assign w_lane_out[l] = SBOX[w_lane_in[l]];
    end

    // Work state with the current byte group replaced by its substituted bytes.
    always_comb begin
        w_work_sub = r_work;
        for (int l = 0; l < LANES; l++) begin
            w_work_sub[w_lane_pos[l] +: 8] = w_lane_out[l];
        end
    end

    // FSM: capture in IDLE, substitute one group per cycle in BUSY, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work  <= in;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_work <= w_work_sub;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_BUSY);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_work;

endmodule

// File: tb/tb_aes_sub_bytes_serial.sv
// tb_aes_sub_bytes_serial
// Three instances of the SubBytes stage (LANES = 1, 4, 16) share clock and
// reset and are exercised one at a time. The reference S-box is built from
// GF(2^8) inversion plus the AES affine transform, and expected states go
// through a scoreboard queue.
module tb_aes_sub_bytes_serial;

    localparam int NDUT = 3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         in_valid_a  [NDUT];
    logic         in_ready_a  [NDUT];
    logic [127:0] in_a        [NDUT];
    logic         out_valid_a [NDUT];
    logic         out_ready_a [NDUT];
    logic [127:0] out_a       [NDUT];
    logic         busy_a      [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes_sub_bytes_serial #(
            .DATA_W (128),
            .LANES  ((g == 0) ? 1 : ((g == 1) ? 4 : 16))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in        (in_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out       (out_a[g]),
            .busy      (busy_a[g])
        );
    end

    // ---------------- reference model ----------------
    logic [7:0] sbox_tab [256];

    function automatic int lanes_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box value from first principles: multiplicative inverse (a^254) then affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // State with the first n bytes (byte 0 upward) substituted, the rest untouched.
    function automatic logic [127:0] sub_prefix(input logic [127:0] v, input int n);
        logic [127:0] r;
        r = v;
        for (int b = 0; b < 16; b++) begin
            if (b < n) r[8*b +: 8] = sbox_tab[v[8*b +: 8]];
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q [$];
    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end at #1 after a rising edge with DUT k in IDLE.
    task automatic wait_done(input int k, input logic [127:0] vec, output int cyc, output int busy_n);
        cyc    = 0;
        busy_n = 0;
        while (out_valid_a[k] !== 1'b1 && cyc < 64) begin
            if (busy_a[k] === 1'b1) busy_n++;
            check($sformatf("partial[%0d]", k), out_a[k], sub_prefix(vec, cyc * lanes_of(k)));
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_vector(input int k, input logic [127:0] vec, input logic [127:0] exp, input int stall);
        int cyc;
        int busy_n;
        logic [127:0] e;
        in_a[k]        = vec;
        in_valid_a[k]  = 1'b1;
        out_ready_a[k] = (stall == 0);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid_a[k] = 1'b0;
        in_a[k]       = {$urandom(), $urandom(), $urandom(), $urandom()};
        check($sformatf("in_ready_busy[%0d]", k), in_ready_a[k], 1'b0);
        wait_done(k, vec, cyc, busy_n);
        check($sformatf("latency[%0d]", k), 128'(cyc), 128'(16 / lanes_of(k)));
        check($sformatf("busy_cycles[%0d]", k), 128'(busy_n), 128'(16 / lanes_of(k)));
        e = exp_q.pop_front();
        for (int s = 0; s < stall; s++) begin
            check($sformatf("stall_valid[%0d]", k), out_valid_a[k], 1'b1);
            check($sformatf("stall_out[%0d]", k), out_a[k], e);
            @(posedge clk); #1;
        end
        out_ready_a[k] = 1'b1;
        check($sformatf("out_valid[%0d]", k), out_valid_a[k], 1'b1);
        check($sformatf("out[%0d]", k), out_a[k], e);
        @(posedge clk); #1;
        check($sformatf("idle_after[%0d]", k), {out_valid_a[k], in_ready_a[k], busy_a[k]}, 3'b010);
    endtask

    task automatic backpressure(input int k);
        logic [127:0] v1;
        logic [127:0] v2;
        logic [127:0] e;
        int cyc;
        int busy_n;
        v1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        v2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_q.push_back(sub_prefix(v1, 16));
        exp_q.push_back(sub_prefix(v2, 16));
        in_a[k]        = v1;
        in_valid_a[k]  = 1'b1;
        out_ready_a[k] = 1'b0;
        @(posedge clk); #1;
        in_valid_a[k] = 1'b0;
        wait_done(k, v1, cyc, busy_n);
        check($sformatf("bp_latency[%0d]", k), 128'(cyc), 128'(16 / lanes_of(k)));
        // Second request held high through DONE must be ignored there.
        in_a[k]       = v2;
        in_valid_a[k] = 1'b1;
        e = exp_q.pop_front();
        for (int s = 0; s < 10; s++) begin
            check($sformatf("bp_hold[%0d]", k), {out_valid_a[k], in_ready_a[k], busy_a[k]}, 3'b100);
            check($sformatf("bp_out[%0d]", k), out_a[k], e);
            @(posedge clk); #1;
        end
        out_ready_a[k] = 1'b1;
        @(posedge clk); #1;
        check($sformatf("bp_idle[%0d]", k), {out_valid_a[k], in_ready_a[k], busy_a[k]}, 3'b010);
        @(posedge clk); #1;
        in_valid_a[k] = 1'b0;
        check($sformatf("bp_accept[%0d]", k), {out_valid_a[k], in_ready_a[k], busy_a[k]}, 3'b001);
        check($sformatf("bp_captured[%0d]", k), out_a[k], v2);
        wait_done(k, v2, cyc, busy_n);
        check($sformatf("bp_latency2[%0d]", k), 128'(cyc), 128'(16 / lanes_of(k)));
        check($sformatf("bp_out2[%0d]", k), out_a[k], exp_q.pop_front());
        @(posedge clk); #1;
        check($sformatf("bp_end[%0d]", k), in_ready_a[k], 1'b1);
    endtask

    task automatic reset_mid_busy();
        logic [127:0] v;
        v = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        in_a[0]        = v;
        in_valid_a[0]  = 1'b1;
        out_ready_a[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_partial", out_a[0], sub_prefix(v, 7));
        check("mid_busy", busy_a[0], 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out_a[0], 128'h0);
        check("async_rst_flags", {out_valid_a[0], in_ready_a[0], busy_a[0]}, 3'b010);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", {out_valid_a[0], in_ready_a[0], busy_a[0]}, 3'b010);
        run_vector(0, v, 128'hd42711aee0bf98f1b8b45de51e415230, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] v;
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            in_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b0;
            in_a[k]        = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_out[%0d]", k), out_a[k], 128'h0);
            check($sformatf("rst_flags[%0d]", k), {out_valid_a[k], in_ready_a[k], busy_a[k]}, 3'b010);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("idle_out[%0d]", k), out_a[k], 128'h0);
            check($sformatf("idle_flags[%0d]", k), {out_valid_a[k], in_ready_a[k], busy_a[k]}, 3'b010);
        end

        for (int k = 0; k < NDUT; k++) begin
            run_vector(k, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 0);
            run_vector(k, {16{8'h00}}, {16{8'h63}}, 0);
            run_vector(k, {16{8'hff}}, {16{8'h16}}, 1);
            run_vector(k, {8{16'h5301}}, {8{16'hed7c}}, 0);
            for (int r = 0; r < 4; r++) begin
                v = {$urandom(), $urandom(), $urandom(), $urandom()};
                run_vector(k, v, sub_prefix(v, 16), int'($urandom_range(0, 3)));
            end
            backpressure(k);
        end

        reset_mid_busy();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_serial.md
Name: aes_sub_bytes_serial

Overview:
- Iterative AES SubBytes stage that sits directly upstream of the ShiftRows/MixColumns datapath.
- Accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES shared forward S-box instances.
- Holds the substituted state until the downstream stage consumes it.
- Trades area (one S-box per lane instead of 16) for 16/LANES cycles of latency.

Parameters:
- DATA_W, 128, state width; fixed at 128, any other value is an elaboration error.
- LANES, 1, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream state valid.
- in_ready  output  1  block can accept a state.
- in  input  DATA_W  input state. Byte k is in[8k+7:8k]; byte 15 is at [127:120], matching MixColumns column packing.
- out_valid  output  1  substituted state available.
- out_ready  input  1  downstream accepts out.
- out  output  DATA_W  substituted state, same byte packing as in.
- busy  output  1  high while substitution is in progress (BUSY state).

Behaviour:
- States: IDLE, BUSY, DONE. Internal registers: work[127:0]; cnt of width log2(16/LANES), minimum 1 bit.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, work=0, cnt=0.
  - Outputs: out=0, out_valid=0, busy=0, in_ready=1.
  - Reset mid-operation discards the partial state; no output is produced for it.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. busy=1 only in BUSY. All are decoded from registered state; no combinational path from in_valid/out_ready to any output.
- IDLE:
  - On in_valid&&in_ready at edge T: work<=in, cnt<=0, go BUSY.
  - in_valid alone with no handshake: no change.
- BUSY:
  - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of work are replaced by their S-box values (FIPS-197 forward table); all other bytes hold.
  - cnt increments each cycle.
  - On the cycle processing the last group (cnt=16/LANES-1): cnt<=0, go DONE.
  - in_valid is ignored in BUSY (in_ready=0).
- DONE:
  - out=work, stable; out_valid held high until out_ready=1.
  - On out_valid&&out_ready: go IDLE next edge.
  - No new input is accepted in DONE or on the same edge as the output handshake.
- Latency: input handshake at edge T -> out_valid high after edge T+16/LANES (16 cycles for LANES=1, 1 cycle for LANES=16).
- Throughput: one state per 16/LANES+2 cycles with out_ready tied high.
- out is driven from work at all times, but is only meaningful while out_valid=1. While BUSY, out shows the partially substituted state.
- S-box: purely combinational 256-entry constant lookup, one instance per lane, no pipeline register inside the lane.
- Upstream back-to-back requests: a second in_valid held through BUSY/DONE is accepted in the first IDLE cycle after the output handshake.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles -> out=0, out_valid=0, busy=0, in_ready=1. Release -> unchanged until in_valid.
- FIPS-197 vector, LANES=1:
  - in=128'h193de3bea0f4e22b9ac68d2ae9f84808 accepted at T -> out_valid rises after T+16.
  - out=128'hd42711aee0bf98f1b8b45de51e415230.
  - busy high for exactly 16 cycles.
- Same vector with LANES=4 and LANES=16 -> identical out. out_valid after T+4 and T+1 respectively.
- Table corners:
  - in all 8'h00 -> out all 8'h63.
  - in all 8'hff -> out all 8'h16.
  - in bytes 8'h01/8'h53 alternating -> 8'h7c/8'hed in matching positions.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, held input accepted in that IDLE cycle.
- Reset mid-BUSY: assert rst_n=0 at cnt=7 (LANES=1) -> out_valid, busy, work, out cleared asynchronously without waiting for clk. After release, a new vector completes correctly in 16 cycles.
